// File: rtl/adain_out_stage.sv
// AdaIN output stage: rounds, saturates and optionally rectifies the MAC result,
// and owns valid/ready flow control around the fixed-latency MAC.
module adain_out_stage #(
    parameter int unsigned ACC_WIDTH   = 112,
    parameter int unsigned WIDTH_OUT   = 16,
    parameter int unsigned FRAC_SHIFT  = 32,
    parameter int unsigned MAC_LATENCY = 2,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_valid,
    output logic                        s_ready,
    output logic                        mac_en,
    input  logic signed [ACC_WIDTH-1:0] mac_out,
    input  logic                        relu_en,
    output logic signed [WIDTH_OUT-1:0] m_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic                        sat_flag,
    output logic [CNT_WIDTH-1:0]        sat_count,
    input  logic                        sat_clr
);

    localparam logic signed [ACC_WIDTH:0] ROUND_HALF =
        {{ACC_WIDTH{1'b0}}, 1'b1} << (FRAC_SHIFT - 1);
    localparam logic signed [ACC_WIDTH:0] SAT_HI =
        {{(ACC_WIDTH + 2 - WIDTH_OUT){1'b0}}, {(WIDTH_OUT - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] SAT_LO =
        {{(ACC_WIDTH + 2 - WIDTH_OUT){1'b1}}, {(WIDTH_OUT - 1){1'b0}}};
    localparam logic signed [WIDTH_OUT-1:0] OUT_MAX = {1'b0, {(WIDTH_OUT - 1){1'b1}}};
    localparam logic signed [WIDTH_OUT-1:0] OUT_MIN = {1'b1, {(WIDTH_OUT - 1){1'b0}}};

    logic                        advance;
    logic                        capture;
    logic [MAC_LATENCY:1]        vld;
    logic signed [ACC_WIDTH:0]   acc_ext;
    logic signed [ACC_WIDTH:0]   acc_rnd;
    logic signed [WIDTH_OUT-1:0] res;
    logic                        res_sat;

    // One stall signal freezes MAC, valid tokens and output together,
    // so mac_out always lines up with vld[MAC_LATENCY].
    assign advance = !m_valid || m_ready;
    assign mac_en  = advance;
    assign s_ready = advance;
    assign capture = advance && vld[MAC_LATENCY];

    always_comb begin
        acc_ext = {mac_out[ACC_WIDTH-1], mac_out};
        acc_rnd = (acc_ext + ROUND_HALF) >>> FRAC_SHIFT;
    end

    always_comb begin
        res     = acc_rnd[WIDTH_OUT-1:0];
        res_sat = 1'b0;
        if (relu_en && (acc_rnd < 0)) begin
            res = '0;
        end else if (acc_rnd > SAT_HI) begin
            res     = OUT_MAX;
            res_sat = 1'b1;
        end else if (acc_rnd < SAT_LO) begin
            res     = OUT_MIN;
            res_sat = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
        end else if (advance) begin
            vld[1] <= s_valid;
            for (int unsigned k = 2; k <= MAC_LATENCY; k++) begin
                vld[k] <= vld[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
        end else if (advance) begin
            m_valid <= vld[MAC_LATENCY];
            if (vld[MAC_LATENCY]) begin
                m_data <= res;
            end
        end
    end

    // Clear wins over a coincident event; that event is dropped.
    always_ff @(posedge clk) begin
        if (rst || sat_clr) begin
            sat_flag  <= 1'b0;
            sat_count <= '0;
        end else if (capture && res_sat) begin
            sat_flag <= 1'b1;
            if (sat_count != '1) begin
                sat_count <= sat_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adain_out_stage.sv
// Self-checking bench for adain_out_stage: behavioural MAC, queue scoreboard,
// directed spec scenarios plus randomized traffic.
module tb_adain_out_stage;

    localparam longint HALF = 64'sd2147483648;

    logic                clk = 1'b0;
    logic                rst, s_valid, s_ready, mac_en, relu_en;
    logic                m_valid, m_ready, sat_flag, sat_clr;
    logic signed [111:0] mac_out;
    logic signed [111:0] opnd = '0;
    logic signed [111:0] st1 = '0;
    logic signed [111:0] st2 = '0;
    logic signed [15:0]  m_data;
    logic [15:0]         sat_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic signed [15:0] exp_q[$];
    int                 exp_sat  = 0;
    logic               exp_flag = 1'b0;
    logic               stall_prev = 1'b0;
    logic signed [15:0] held = '0;
    logic signed [15:0] mon_y;
    logic               mon_sat;

    always #5 clk = ~clk;

    adain_out_stage #(
        .ACC_WIDTH  (112),
        .WIDTH_OUT  (16),
        .FRAC_SHIFT (32),
        .MAC_LATENCY(2),
        .CNT_WIDTH  (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .mac_en   (mac_en),
        .mac_out  (mac_out),
        .relu_en  (relu_en),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .sat_flag (sat_flag),
        .sat_count(sat_count),
        .sat_clr  (sat_clr)
    );

    // Two-stage MAC stand-in: the operand itself is the product result.
    always @(posedge clk) begin
        if (mac_en) begin
            st1 <= opnd;
            st2 <= st1;
        end
    end
    assign mac_out = st2;

    task automatic chk(input string name, input longint act, input longint expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    function automatic logic signed [111:0] fx(input longint ip, input longint fr);
        logic signed [111:0] a;
        a = ip;
        a = a <<< 32;
        a = a + fr;
        return a;
    endfunction

    // Floor((x + 0.5) / 2^32), then rectify / clamp to 16-bit signed.
    function automatic void ref_f(input logic signed [111:0] x, input logic relu,
                                  output logic signed [15:0] y, output logic sat);
        logic signed [112:0] num, den, q;
        num = x;
        num = num + 113'sd2147483648;
        den = 113'sd4294967296;
        q   = num / den;
        if (num < 0 && (num % den) != 0) q = q - 1;
        sat = 1'b0;
        if (relu && q < 0) begin
            y = '0;
        end else if (q > 32767) begin
            y   = 16'sh7fff;
            sat = 1'b1;
        end else if (q < -32768) begin
            y   = 16'sh8000;
            sat = 1'b1;
        end else begin
            y = q[15:0];
        end
    endfunction

    function automatic logic signed [111:0] gen_val();
        int unsigned m = $urandom_range(0, 9);
        logic signed [111:0] v;
        if (m < 7)       v = fx(longint'($urandom_range(0, 80000)) - 40000, longint'($urandom));
        else if (m == 7) v = fx(longint'($urandom_range(0, 80000)) - 40000, HALF);
        else             v = {16'($urandom), $urandom, $urandom, $urandom};
        return v;
    endfunction

    // Scoreboard and per-cycle protocol checks.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_sat    = 0;
            exp_flag   = 1'b0;
            stall_prev = 1'b0;
        end else begin
            chk("mac_en_eq_s_ready", mac_en, s_ready);
            chk("s_ready_rule", s_ready, !m_valid || m_ready);
            if (stall_prev) begin
                chk("stall_hold_valid", m_valid, 1);
                chk("stall_hold_data", m_data, held);
            end
            if (m_valid && m_ready) begin
                chk("output_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) chk("m_data", m_data, exp_q.pop_front());
            end
            if (sat_clr) begin
                exp_sat  = 0;
                exp_flag = 1'b0;
            end
            if (s_valid && s_ready) begin
                ref_f(opnd, relu_en, mon_y, mon_sat);
                exp_q.push_back(mon_y);
                if (mon_sat) begin
                    exp_flag = 1'b1;
                    if (exp_sat < 65535) exp_sat++;
                end
            end
            stall_prev = m_valid && !m_ready;
            held       = m_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic signed [111:0] v);
        s_valid = 1'b1;
        opnd    = v;
        tick();
        s_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        while ((exp_q.size() != 0 || m_valid) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_drain_in_time"}, n < 20, 1);
        chk({tag, "_sat_count"}, sat_count, exp_sat);
        chk({tag, "_sat_flag"}, sat_flag, exp_flag);
        tick();
    endtask

    task automatic lat_tok(input logic signed [111:0] v, input longint lit, input string name);
        int n;
        s_valid = 1'b1;
        opnd    = v;
        tick();
        s_valid = 1'b0;
        n = 1;
        @(negedge clk);
        while (!m_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_latency"}, n, 3);
        chk({name, "_data"}, m_data, lit);
        tick();
    endtask

    initial begin
        logic signed [15:0] y;
        logic               s;
        int                 sent, hs, last;
        logic               mv[1:12];

        rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0; relu_en = 1'b0; sat_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_m_valid", m_valid, 0);
        chk("reset_m_data", m_data, 0);
        chk("reset_sat_flag", sat_flag, 0);
        chk("reset_sat_count", sat_count, 0);
        tick();

        ref_f(fx(3, HALF), 1'b0, y, s);        chk("model_3p5", y, 4);
        ref_f(fx(0, -HALF), 1'b0, y, s);       chk("model_m0p5", y, 0);
        ref_f(fx(-1, -HALF), 1'b0, y, s);      chk("model_m1p5", y, -1);
        ref_f(fx(2, HALF / 2), 1'b0, y, s);    chk("model_2p25", y, 2);
        ref_f(fx(40000, 0), 1'b0, y, s);       chk("model_sat_hi", y, 32767); chk("model_sat_hi_ev", s, 1);
        ref_f(fx(-40000, 0), 1'b0, y, s);      chk("model_sat_lo", y, -32768);
        ref_f(fx(32767, 0), 1'b0, y, s);       chk("model_edge_ev", s, 0);
        ref_f(fx(-5, 0), 1'b1, y, s);          chk("model_relu", y, 0); chk("model_relu_ev", s, 0);

        m_ready = 1'b1;
        lat_tok(fx(3, HALF), 4, "round_3p5");
        lat_tok(fx(0, -HALF), 0, "round_m0p5");
        lat_tok(fx(-1, -HALF), -1, "round_m1p5");
        lat_tok(fx(2, HALF / 2), 2, "round_2p25");
        drain("rounding");
        chk("rounding_no_sat", sat_count, 0);

        send(fx(40000, 0));
        send(fx(-40000, 0));
        send(fx(32767, 0));
        drain("saturation");
        chk("sat_count_2", sat_count, 2);
        chk("sat_flag_set", sat_flag, 1);

        relu_en = 1'b1;
        send(fx(-5, 0));
        send(fx(7, 0));
        drain("relu");
        chk("relu_sat_unchanged", sat_count, 2);
        relu_en = 1'b0;

        sent = 0; hs = 0; last = 0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            s_valid = sent < 6;
            opnd    = fx(sent + 1, 0);
            m_ready = !(cyc >= 4 && cyc <= 8);
            @(negedge clk);
            if (s_valid && s_ready) sent++;
            if (cyc >= 4 && cyc <= 8) begin
                chk("bp_s_ready_low", s_ready, 0);
                chk("bp_mac_en_low", mac_en, 0);
            end
            if (m_valid && m_ready) begin
                hs++;
                last = cyc;
            end
            if (hs == 6) break;
            tick();
        end
        tick();
        chk("bp_outputs", hs, 6);
        chk("bp_total_cycles", last, 14);
        drain("backpressure");

        for (int cyc = 1; cyc <= 12; cyc++) begin
            s_valid = (cyc <= 8) && (cyc % 2 == 1);
            opnd    = fx(cyc, 0);
            @(negedge clk);
            mv[cyc] = m_valid;
            tick();
        end
        for (int cyc = 1; cyc <= 12; cyc++) begin
            chk("bubble_pattern", mv[cyc], (cyc > 3) && (cyc - 3 <= 8) && ((cyc - 3) % 2 == 1));
        end
        drain("bubbles");

        for (int blk = 0; blk < 4; blk++) begin
            relu_en = blk[0];
            for (int i = 0; i < 150; i++) begin
                s_valid = $urandom_range(0, 3) != 0;
                m_ready = $urandom_range(0, 9) < 7;
                opnd    = gen_val();
                tick();
            end
            drain("random");
        end
        relu_en = 1'b0;

        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        s_valid = 1'b1;
        opnd    = fx(40000, 0);
        repeat (65535) tick();
        drain("preload");
        chk("sat_count_max", sat_count, 65535);
        send(fx(-40000, 0));
        drain("beyond_max");
        chk("sat_count_held", sat_count, 65535);

        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        send(fx(40000, 0));
        tick();
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        drain("clr_vs_event");
        chk("clr_priority_count", sat_count, 0);
        chk("clr_priority_flag", sat_flag, 0);

        m_ready = 1'b0;
        send(fx(11, 0));
        send(fx(12, 0));
        send(fx(13, 0));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("midreset_m_valid", m_valid, 0);
        chk("midreset_m_data", m_data, 0);
        tick();
        m_ready = 1'b1;
        lat_tok(fx(21, 0), 21, "post_reset");
        drain("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
